// File: rtl/buzzer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : buzzer_arbiter
//  Description : Round-based buzz-in arbiter for four player controllers.
//                Opens a timed answer window, grants one player using a
//                rotating priority, captures that player's switch answer and
//                holds it for the CPU until ack/abort. Early buzzers receive
//                a timed lockout.
//  Revision    : 1.0 - initial release
// ============================================================================
module buzzer_arbiter #(
    parameter int WINDOW_CYCLES  = 500000000,
    parameter int PENALTY_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic [31:0] sw_bus,
    input  logic        round_start,
    input  logic        round_abort,
    input  logic        result_ack,
    output logic        armed,
    output logic        result_valid,
    output logic [1:0]  winner_id,
    output logic [7:0]  answer,
    output logic        timeout_pulse,
    output logic [3:0]  locked_out
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int PEN_W = $clog2(PENALTY_CYCLES + 1);

    localparam logic [WIN_W-1:0] C_WIN_LOAD = WIN_W'(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] C_WIN_ONE  = WIN_W'(1);
    localparam logic [PEN_W-1:0] C_PEN_LOAD = PEN_W'(PENALTY_CYCLES);
    localparam logic [PEN_W-1:0] C_PEN_ONE  = PEN_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_prev_btn;
    logic [3:0]       w_rise;
    logic [3:0]       w_eligible;
    logic [3:0]       w_pen_load;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] w_win_cnt_nxt;
    logic [1:0]       r_rr_ptr;
    logic [1:0]       w_rr_ptr_nxt;
    logic             w_grant_found;
    logic [1:0]       w_grant_idx;
    logic [1:0]       w_scan_idx;
    logic             w_armed_nxt;
    logic             w_valid_nxt;
    logic [1:0]       w_winner_nxt;
    logic [7:0]       w_answer_nxt;
    logic             w_timeout_nxt;

    // Edge detect: only a fresh press counts; locked players cannot win.
    assign w_rise     = btn & ~r_prev_btn;
    assign w_eligible = w_rise & ~locked_out;
    // Penalties are only handed out while no window is open.
    assign w_pen_load = (r_state == ST_IDLE) ? w_rise : 4'b0000;

    // Rotating-priority pick: first eligible player starting at r_rr_ptr.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = 2'd0;
        w_scan_idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_scan_idx = r_rr_ptr + 2'(k);
            if (!w_grant_found && w_eligible[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks grant, grant outranks timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (round_start) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (round_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_grant_found) begin
                    w_state_nxt = ST_VALID;
                end else if (r_win_cnt == C_WIN_ONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_VALID: begin
                if (round_abort || result_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values, registered below so every output is a flop.
    always_comb begin
        w_armed_nxt   = armed;
        w_valid_nxt   = result_valid;
        w_winner_nxt  = winner_id;
        w_answer_nxt  = answer;
        w_timeout_nxt = 1'b0;
        w_win_cnt_nxt = r_win_cnt;
        w_rr_ptr_nxt  = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (round_start) begin
                    w_armed_nxt   = 1'b1;
                    w_win_cnt_nxt = C_WIN_LOAD;
                end
            end
            ST_ARMED: begin
                if (round_abort) begin
                    w_armed_nxt = 1'b0;
                end else if (w_grant_found) begin
                    w_winner_nxt = w_grant_idx;
                    w_answer_nxt = sw_bus[{w_grant_idx, 3'b000} +: 8];
                    w_valid_nxt  = 1'b1;
                    w_armed_nxt  = 1'b0;
                end else if (r_win_cnt == C_WIN_ONE) begin
                    w_timeout_nxt = 1'b1;
                    w_armed_nxt   = 1'b0;
                end else begin
                    w_win_cnt_nxt = r_win_cnt - C_WIN_ONE;
                end
            end
            ST_VALID: begin
                if (round_abort) begin
                    w_valid_nxt = 1'b0;
                end else if (result_ack) begin
                    w_valid_nxt  = 1'b0;
                    w_rr_ptr_nxt = winner_id + 2'd1;
                end
            end
            default: begin
                w_armed_nxt = 1'b0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; prev_btn resets high so held buttons are not presses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            armed         <= 1'b0;
            result_valid  <= 1'b0;
            winner_id     <= 2'd0;
            answer        <= 8'd0;
            timeout_pulse <= 1'b0;
            r_win_cnt     <= '0;
            r_rr_ptr      <= 2'd0;
            r_prev_btn    <= 4'b1111;
        end else begin
            armed         <= w_armed_nxt;
            result_valid  <= w_valid_nxt;
            winner_id     <= w_winner_nxt;
            answer        <= w_answer_nxt;
            timeout_pulse <= w_timeout_nxt;
            r_win_cnt     <= w_win_cnt_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_prev_btn    <= btn;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pen
            logic [PEN_W-1:0] r_pen_cnt;
            logic             r_locked;

            // Per-player lockout counter; the flag mirrors counter != 0 one flop early.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_pen_cnt <= '0;
                    r_locked  <= 1'b0;
                end else if (w_pen_load[gi]) begin
                    r_pen_cnt <= C_PEN_LOAD;
                    r_locked  <= (C_PEN_LOAD != '0);
                end else if (r_pen_cnt != '0) begin
                    r_pen_cnt <= r_pen_cnt - C_PEN_ONE;
                    r_locked  <= (r_pen_cnt != C_PEN_ONE);
                end
            end

            assign locked_out[gi] = r_locked;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_buzzer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buzzer_arbiter
//  Description : Directed and randomized checks of buzzer_arbiter against a
//                behavioural round model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_arbiter;

    localparam int WIN = 20;
    localparam int PEN = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic [31:0] sw_bus;
    logic        round_start;
    logic        round_abort;
    logic        result_ack;
    logic        armed;
    logic        result_valid;
    logic [1:0]  winner_id;
    logic [7:0]  answer;
    logic        timeout_pulse;
    logic [3:0]  locked_out;

    buzzer_arbiter #(
        .WINDOW_CYCLES  (WIN),
        .PENALTY_CYCLES (PEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn           (btn),
        .sw_bus        (sw_bus),
        .round_start   (round_start),
        .round_abort   (round_abort),
        .result_ack    (result_ack),
        .armed         (armed),
        .result_valid  (result_valid),
        .winner_id     (winner_id),
        .answer        (answer),
        .timeout_pulse (timeout_pulse),
        .locked_out    (locked_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of one round: phase 0 = waiting, 1 = window open, 2 = result held
    int m_phase;
    int m_left;
    int m_rr;
    int m_winner;
    int m_answer;
    int m_pen[4];
    bit m_prev[4];
    bit m_armed;
    bit m_valid;
    bit m_to;

    int exp_w[4] = '{3, 1, 3, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        bit rise[4];
        bit penalise[4];
        bit found;
        int g;
        int idx;
        if (!rst) begin
            m_phase = 0; m_left = 0; m_rr = 0; m_winner = 0; m_answer = 0;
            m_armed = 0; m_valid = 0; m_to = 0;
            for (int i = 0; i < 4; i++) begin
                m_pen[i]  = 0;
                m_prev[i] = 1;
            end
            return;
        end
        m_to  = 0;
        found = 0;
        g     = 0;
        for (int i = 0; i < 4; i++) begin
            rise[i]     = btn[i] && !m_prev[i];
            penalise[i] = 0;
        end
        if (m_phase == 0) begin
            for (int i = 0; i < 4; i++) penalise[i] = rise[i];
            if (round_start) begin
                m_phase = 1; m_left = WIN; m_armed = 1;
            end
        end else if (m_phase == 1) begin
            if (round_abort) begin
                m_phase = 0; m_armed = 0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    idx = (m_rr + k) % 4;
                    if (!found && rise[idx] && m_pen[idx] == 0) begin
                        found = 1; g = idx;
                    end
                end
                if (found) begin
                    m_winner = g;
                    m_answer = int'((sw_bus >> (8 * g)) & 32'hFF);
                    m_valid  = 1; m_armed = 0; m_phase = 2;
                end else if (m_left == 1) begin
                    m_to = 1; m_armed = 0; m_phase = 0;
                end else begin
                    m_left = m_left - 1;
                end
            end
        end else begin
            if (round_abort) begin
                m_valid = 0; m_phase = 0;
            end else if (result_ack) begin
                m_valid = 0; m_rr = (m_winner + 1) % 4; m_phase = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (penalise[i]) m_pen[i] = PEN;
            else if (m_pen[i] > 0) m_pen[i] = m_pen[i] - 1;
            m_prev[i] = btn[i];
        end
    endfunction

    // Advance one clock and compare every output with the model.
    task automatic tick();
        logic [3:0] el;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) el[i] = (m_pen[i] != 0);
        chk("m_armed",   armed,         m_armed);
        chk("m_valid",   result_valid,  m_valid);
        chk("m_winner",  winner_id,     m_winner);
        chk("m_answer",  answer,        m_answer);
        chk("m_timeout", timeout_pulse, m_to);
        chk("m_locked",  locked_out,    el);
    endtask

    initial begin
        logic [31:0] sw_tmp;
        rst = 1'b0; btn = 4'b0000; sw_bus = 32'd0;
        round_start = 1'b0; round_abort = 1'b0; result_ack = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_armed", armed, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_locked", locked_out, 0);
        rst = 1'b1;
        tick(); tick();

        // Single buzz from player 2
        round_start = 1'b1; tick(); round_start = 1'b0;
        chk("start_armed", armed, 1);
        tick(); tick();
        btn = 4'b0100; sw_bus = 32'h00A5_0000;
        tick();
        chk("single_valid", result_valid, 1);
        chk("single_winner", winner_id, 2);
        chk("single_answer", answer, 8'hA5);
        chk("single_armed", armed, 0);
        btn = 4'b0000; result_ack = 1'b1; tick(); result_ack = 1'b0;
        chk("single_ack_valid", result_valid, 0);

        // Coincident presses: rotation from rr=3, then 0, 2, 0
        for (int r = 0; r < 4; r++) begin
            round_start = 1'b1; tick(); round_start = 1'b0;
            tick();
            btn = 4'b1010; sw_tmp = $urandom; sw_bus = sw_tmp;
            tick();
            chk("rot_winner", winner_id, exp_w[r]);
            chk("rot_answer", answer, (sw_tmp >> (8 * exp_w[r])) & 32'hFF);
            btn = 4'b0000; result_ack = 1'b1; tick(); result_ack = 1'b0;
        end

        // Early buzz lockout lasts exactly PEN cycles
        btn = 4'b0001; tick();
        chk("pen_first", locked_out, 4'b0001);
        btn = 4'b0000;
        for (int i = 0; i < PEN - 1; i++) begin
            tick();
            chk("pen_hold", locked_out, 4'b0001);
        end
        tick();
        chk("pen_clear", locked_out, 4'b0000);
        btn = 4'b0001; tick();
        btn = 4'b0000; round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 4'b0001; tick();
        chk("locked_nogrant", result_valid, 0);
        chk("locked_noextend", locked_out, 4'b0001);
        btn = 4'b1001; tick();
        chk("locked_other_valid", result_valid, 1);
        chk("locked_other_winner", winner_id, 3);
        btn = 4'b0000; result_ack = 1'b1; tick(); result_ack = 1'b0;

        // Timeout with no presses
        round_start = 1'b1; tick(); round_start = 1'b0;
        for (int i = 0; i < WIN - 1; i++) begin
            tick();
            chk("to_armed", armed, 1);
            chk("to_nopulse", timeout_pulse, 0);
        end
        tick();
        chk("to_pulse", timeout_pulse, 1);
        chk("to_disarm", armed, 0);
        chk("to_novalid", result_valid, 0);
        tick();
        chk("to_pulse_end", timeout_pulse, 0);

        // Abort during the window
        round_start = 1'b1; tick(); round_start = 1'b0;
        tick();
        round_abort = 1'b1; tick(); round_abort = 1'b0;
        chk("abort_armed", armed, 0);
        chk("abort_nopulse", timeout_pulse, 0);
        for (int i = 0; i < WIN + 2; i++) begin
            tick();
            chk("abort_quiet", timeout_pulse, 0);
        end

        // Result held stable while players keep pressing
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 4'b0001; sw_bus = 32'h0000_003C; tick();
        chk("hold_winner0", winner_id, 0);
        for (int i = 0; i < 6; i++) begin
            btn = 4'($urandom); sw_bus = $urandom; tick();
            chk("hold_winner", winner_id, 0);
            chk("hold_answer", answer, 8'h3C);
            chk("hold_valid", result_valid, 1);
        end
        btn = 4'b0000; round_abort = 1'b1; tick(); round_abort = 1'b0;
        chk("hold_abort_valid", result_valid, 0);

        // Reset mid-result with button held through it
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 4'b0010; tick();
        chk("pre_rst_winner", winner_id, 1);
        rst = 1'b0; tick();
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_winner", winner_id, 0);
        chk("mid_rst_answer", answer, 0);
        chk("mid_rst_armed", armed, 0);
        rst = 1'b1; round_start = 1'b1; tick(); round_start = 1'b0;
        chk("post_rst_armed", armed, 1);
        tick(); tick();
        chk("held_nogrant", result_valid, 0);
        btn = 4'b0000; tick();
        btn = 4'b0010; tick();
        chk("repress_valid", result_valid, 1);
        chk("repress_winner", winner_id, 1);
        btn = 4'b0000; result_ack = 1'b1; tick(); result_ack = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 15) == 0) btn = 4'($urandom);
            else if ($urandom_range(0, 3) == 0) btn = btn ^ 4'(1 << $urandom_range(0, 3));
            sw_bus      = $urandom;
            round_start = ($urandom_range(0, 7) == 0);
            round_abort = ($urandom_range(0, 39) == 0);
            result_ack  = !round_abort && ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
Round-based buzz-in arbiter for the four player controllers. It opens a timed answer window on request from the game CPU and grants exactly one player, using rotating priority when presses coincide. It captures the winning player's 8-bit switch answer and presents it to the CPU with a valid/ack handshake. Players who buzz before the window opens get a timed lockout penalty.

Parameters:
WINDOW_CYCLES, 500000000, answer-window length in clk cycles (10 s at 50 MHz); counter width is $clog2(WINDOW_CYCLES+1).
PENALTY_CYCLES, 50000000, early-buzz lockout length in clk cycles (1 s at 50 MHz); per-player counter width is $clog2(PENALTY_CYCLES+1).

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  synchronous, active-low reset.
btn  input  4  debounced player buttons, active-high; bit i is player i (0 = p1).
sw_bus  input  32  player switches; player i occupies [8i+7:8i].
round_start  input  1  single-cycle request to open the answer window.
round_abort  input  1  single-cycle request to cancel the round.
result_ack  input  1  CPU has consumed the result.
armed  output  1  high while the answer window is open.
result_valid  output  1  high while winner_id/answer are held for the CPU.
winner_id  output  2  index of the granted player.
answer  output  8  granted player's switch value, captured at grant.
timeout_pulse  output  1  one-cycle pulse when the window expires with no grant.
locked_out  output  4  per-player penalty active.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; armed, result_valid, timeout_pulse=0; winner_id=0; answer=0; locked_out=0; all counters=0; rr_ptr=0; prev_btn=4'b1111, so a button held through reset does not register as a press.
- Press detection: rise[i] = btn[i] & ~prev_btn[i]; prev_btn<=btn every cycle. Only rising edges count. A held button never re-triggers.
- Lockout: locked_out[i] = (pen_cnt[i]!=0). Each nonzero counter decrements by 1 per cycle. Loading sets the counter to PENALTY_CYCLES. A rise while the counter is nonzero reloads it, so the penalty restarts.
- States: IDLE, ARMED, VALID. All outputs are registered.
- IDLE:
  - Any rise[i] loads pen_cnt[i].
  - round_start -> ARMED, win_cnt<=WINDOW_CYCLES, armed<=1.
  - If round_start and a rise occur in the same cycle, the press is penalised and the window still opens.
  - round_abort and result_ack are ignored.
- ARMED:
  - eligible = rise & ~locked_out. Rises from locked players are ignored and do not extend the penalty.
  - If eligible!=0, grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod 4. In the same edge: winner_id<=g, answer<=sw_bus[8g+7:8g], result_valid<=1, armed<=0, state VALID.
  - Latency is one cycle: a rise sampled at edge N gives result_valid=1 after edge N.
  - Otherwise win_cnt decrements. When win_cnt==1 and there is no eligible press: timeout_pulse<=1 for one cycle, armed<=0, state IDLE.
  - A grant on the final window cycle beats timeout.
  - round_abort has priority over grant and timeout: -> IDLE, armed<=0, no pulse.
  - round_start is ignored.
- VALID:
  - winner_id and answer are held stable. Presses are ignored, with no penalty.
  - result_ack -> result_valid<=0, rr_ptr<=winner_id+1 (2-bit wrap), state IDLE.
  - round_abort -> same as ack, except rr_ptr is unchanged.
  - round_start is ignored.
- Penalty counters keep running in every state.
- A reset mid-round returns all state to the reset values above.

Test Plan:
(Bench parameters: WINDOW_CYCLES=20, PENALTY_CYCLES=8.)
- Single buzz: round_start; 3 cycles later btn=4'b0100, sw_bus[23:16]=8'hA5 -> result_valid=1 one cycle after the rise, winner_id=2, answer=8'hA5, armed=0. Assert ack -> valid=0, rr_ptr=3.
- Simultaneous buzz and rotation: rr_ptr=0, btn=4'b1010 in the same cycle -> winner_id=1. Ack, new round, same press -> winner_id=3 (rr_ptr=2). Ack, new round, same press -> winner_id=1 (rr_ptr wrapped to 0).
- Early buzz penalty: in IDLE, btn[0] rises -> locked_out=4'b0001 for exactly 8 cycles. round_start, then btn[0] re-rises during the lockout -> no grant. btn[3] rises -> winner_id=3.
- Timeout: round_start with no presses -> armed high 20 cycles, then timeout_pulse=1 for exactly one cycle, armed=0, result_valid never asserted.
- Abort and hold: round_abort during ARMED -> IDLE with no pulse. In VALID, toggle btn and change sw_bus -> winner_id and answer are unchanged.
- Reset: rst=0 during VALID with btn[1] held -> all outputs 0. Release rst, round_start with btn[1] still held -> no grant until btn[1] is released and pressed again.
